// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - decodes "W <addr> <data>\r\n" / "R <addr>\r\n" byte streams into commands
// Define UART_CMD_LOWER_EN to also accept lowercase opcodes and hex digits.
`timescale 1ns/1ps
module uart_cmd_parser #(
  parameter int ADDR_HEX    = 4,
  parameter int DATA_HEX    = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  DATA_EN,
  input  logic [7:0]            DATA_IN,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic                  CMD_WR,
  output logic                  CMD_RD,
  output logic [4*ADDR_HEX-1:0] ADDR,
  output logic [4*DATA_HEX-1:0] DATA,
  output logic                  FAIL,
  output logic [1:0]            ERR_CODE,
  output logic                  OVERRUN,
  output logic                  BUSY
);
  localparam int AW     = 4 * ADDR_HEX;
  localparam int DW     = 4 * DATA_HEX;
  localparam int MAXHEX = (ADDR_HEX > DATA_HEX) ? ADDR_HEX : DATA_HEX;
  localparam int CW     = $clog2(MAXHEX + 1);
  localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] A_LAST  = CW'(ADDR_HEX - 1);
  localparam logic [CW-1:0] D_LAST  = CW'(DATA_HEX - 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [7:0] CH_LF = 8'h0A, CH_CR = 8'h0D, CH_SP = 8'h20;
`ifdef UART_CMD_LOWER_EN
  localparam bit LOWER_EN = 1'b1;
`else
  localparam bit LOWER_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_SEP1, S_ADDR, S_SEP2, S_DATA, S_CR, S_LF, S_DISCARD, S_HOLD
  } state_t;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (LOWER_EN && b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  function automatic logic is_op(input logic [7:0] b, input logic [7:0] upper);
    return (b == upper) || (LOWER_EN && b == (upper | 8'h20));
  endfunction

  function automatic logic timed(input state_t s);
    return (s != S_IDLE) && (s != S_HOLD);
  endfunction

  state_t          state, state_n, cur;
  logic            wr;
  logic [AW-1:0]   addr_sr;
  logic [DW-1:0]   data_sr;
  logic [CW-1:0]   dig_cnt;
  logic [TW-1:0]   tcnt;
  logic            wr_q, rd_q, fail_q, overrun_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [1:0]      err_q, fail_code;
  logic            ack, expired, bad, go_sep1, shift_a, shift_d, cnt_clr, cnt_inc;
  logic            ld_good, ld_fail, drop;

  // A handshake frees the parser this cycle, so a coincident byte is decoded as from IDLE.
  always_comb begin
    ack       = (state == S_HOLD) && CMD_READY;
    cur       = ack ? S_IDLE : state;
    state_n   = cur;
    expired   = (TIMEOUT_CYC != 0) && timed(state) && !DATA_EN && (tcnt == TO_LAST);
    bad       = 1'b0;
    go_sep1   = 1'b0;
    shift_a   = 1'b0;
    shift_d   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ld_good   = 1'b0;
    ld_fail   = 1'b0;
    fail_code = 2'd1;
    drop      = 1'b0;
    if (expired) begin
      state_n   = S_HOLD;
      ld_fail   = 1'b1;
      fail_code = 2'd2;
    end else if (DATA_EN) begin
      case (cur)
        S_IDLE: begin
          if (is_op(DATA_IN, 8'h57) || is_op(DATA_IN, 8'h52)) begin
            state_n = S_SEP1;
            go_sep1 = 1'b1;
          end else if (DATA_IN != CH_LF) begin
            state_n = S_DISCARD;
          end
        end
        S_SEP1, S_SEP2: begin
          if (DATA_IN == CH_SP) begin
            state_n = (cur == S_SEP1) ? S_ADDR : S_DATA;
            cnt_clr = 1'b1;
          end else bad = 1'b1;
        end
        S_ADDR: begin
          if (is_hex(DATA_IN)) begin
            shift_a = 1'b1;
            if (dig_cnt == A_LAST) begin
              state_n = wr ? S_SEP2 : S_CR;
              cnt_clr = 1'b1;
            end else cnt_inc = 1'b1;
          end else bad = 1'b1;
        end
        S_DATA: begin
          if (is_hex(DATA_IN)) begin
            shift_d = 1'b1;
            if (dig_cnt == D_LAST) begin
              state_n = S_CR;
              cnt_clr = 1'b1;
            end else cnt_inc = 1'b1;
          end else bad = 1'b1;
        end
        S_CR: begin
          if (DATA_IN == CH_CR) state_n = S_LF;
          else bad = 1'b1;
        end
        S_LF: begin
          if (DATA_IN == CH_LF) begin
            state_n = S_HOLD;
            ld_good = 1'b1;
          end else bad = 1'b1;
        end
        S_DISCARD: bad = (DATA_IN == CH_LF);
        S_HOLD:    drop = 1'b1;
        default:   state_n = S_IDLE;
      endcase
      if (bad) begin
        if (DATA_IN == CH_LF) begin
          state_n = S_HOLD;
          ld_fail = 1'b1;
        end else state_n = S_DISCARD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      wr        <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      dig_cnt   <= '0;
      tcnt      <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      fail_q    <= 1'b0;
      err_q     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      overrun_q <= drop;
      tcnt      <= (timed(state_n) && !DATA_EN) ? tcnt + 1'b1 : '0;
      if (go_sep1) begin
        wr      <= is_op(DATA_IN, 8'h57);
        addr_sr <= '0;
        data_sr <= '0;
      end
      if (go_sep1 || cnt_clr) dig_cnt <= '0;
      else if (cnt_inc)       dig_cnt <= dig_cnt + 1'b1;
      if (shift_a) addr_sr <= (addr_sr << 4) | AW'(hex_val(DATA_IN));
      if (shift_d) data_sr <= (data_sr << 4) | DW'(hex_val(DATA_IN));
      if (ld_good) begin
        wr_q   <= wr;
        rd_q   <= !wr;
        addr_q <= addr_sr;
        data_q <= wr ? data_sr : '0;
        fail_q <= 1'b0;
        err_q  <= 2'd0;
      end else if (ld_fail || ack) begin
        wr_q   <= 1'b0;
        rd_q   <= 1'b0;
        addr_q <= '0;
        data_q <= '0;
        fail_q <= ld_fail;
        err_q  <= ld_fail ? fail_code : 2'd0;
      end
    end
  end

  assign CMD_VALID = (state == S_HOLD);
  assign BUSY      = (state != S_IDLE);
  assign CMD_WR    = wr_q;
  assign CMD_RD    = rd_q;
  assign ADDR      = addr_q;
  assign DATA      = data_q;
  assign FAIL      = fail_q;
  assign ERR_CODE  = err_q;
  assign OVERRUN   = overrun_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized and directed bench for uart_cmd_parser
// Honours UART_CMD_LOWER_EN in its reference model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int AH = 4, DH = 8, TO = 50;
`ifdef UART_CMD_LOWER_EN
  localparam bit LOWER = 1'b1;
`else
  localparam bit LOWER = 1'b0;
`endif

  typedef logic [7:0] u8;
  typedef u8 bq_t[$];
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic        fail;
    logic [1:0]  err;
  } res_t;

  logic        CLK = 1'b0, RST_N = 1'b1, DATA_EN = 1'b0, CMD_READY = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        CMD_VALID, CMD_WR, CMD_RD, FAIL, OVERRUN, BUSY;
  logic [15:0] ADDR;
  logic [31:0] DATA;
  logic [1:0]  ERR_CODE;

  int   n_checks = 0, n_fail = 0, ovr_cnt = 0;
  res_t got_q[$], exp_q[$];

  uart_cmd_parser #(.ADDR_HEX(AH), .DATA_HEX(DH), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .DATA_EN(DATA_EN), .DATA_IN(DATA_IN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD),
    .ADDR(ADDR), .DATA(DATA), .FAIL(FAIL), .ERR_CODE(ERR_CODE),
    .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST_N && CMD_VALID && CMD_READY) got_q.push_back({CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE});
    if (OVERRUN) ovr_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int hexval(input u8 c);
    string digs = "0123456789ABCDEF";
    u8 u = c;
    if (LOWER && c >= "a" && c <= "f") u = c - 8'h20;
    for (int i = 0; i < 16; i++) if (digs[i] == u) return i;
    return -1;
  endfunction

  // A line ending in LF yields nothing if blank, a good result if it matches the grammar exactly, else a syntax fail.
  function automatic bit model_line(input bq_t q, output res_t r);
    int n, len, v;
    bit ok, is_w, is_r;
    u8 c0;
    r = '0;
    n = q.size();
    if (n == 1 && q[0] == 8'h0A) return 1'b0;
    c0 = q[0];
    if (LOWER && (c0 == "w" || c0 == "r")) c0 = c0 - 8'h20;
    is_w = (c0 == "W");
    is_r = (c0 == "R");
    ok   = is_w || is_r;
    len  = 2 + AH + 2 + (is_w ? 1 + DH : 0);
    if (n != len) ok = 1'b0;
    if (ok) begin
      if (q[1] != " ") ok = 1'b0;
      for (int i = 0; i < AH; i++) begin
        v = hexval(q[2+i]);
        if (v < 0) ok = 1'b0;
        else r.addr = 16'(r.addr * 16 + v);
      end
      if (is_w) begin
        if (q[2+AH] != " ") ok = 1'b0;
        for (int i = 0; i < DH; i++) begin
          v = hexval(q[3+AH+i]);
          if (v < 0) ok = 1'b0;
          else r.data = 32'(r.data * 16 + v);
        end
      end
      if (q[len-2] != 8'h0D || q[len-1] != 8'h0A) ok = 1'b0;
    end
    if (ok) begin
      r.wr = is_w;
      r.rd = is_r;
    end else begin
      r      = '0;
      r.fail = 1'b1;
      r.err  = 2'd1;
    end
    return 1'b1;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t frame(input string s);
    bq_t q = str2q(s);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  function automatic bq_t gen_frame();
    bq_t q;
    string s;
    logic [15:0] a = 16'($urandom);
    logic [31:0] d = $urandom;
    u8 b;
    int pos;
    if ($urandom_range(0, 9) == 0) begin
      q.push_back(8'h0A);
      return q;
    end
    if ($urandom_range(0, 1) == 1) s = $sformatf("W %04X %08X", a, d);
    else s = $sformatf("R %04X", a);
    if ($urandom_range(0, 3) == 0) s = s.tolower();
    q = frame(s);
    if ($urandom_range(0, 2) == 0) begin
      pos = $urandom_range(0, q.size() - 2);
      b = 8'($urandom_range(0, 255));
      if (b == 8'h0A) b = 8'h21;
      case ($urandom_range(0, 2))
        0:       q[pos] = b;
        1:       q.delete(pos);
        default: q.insert(pos, b);
      endcase
    end
    return q;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input u8 b, input int gap);
    DATA_IN = b;
    DATA_EN = 1'b1;
    tick();
    DATA_EN = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_q(input bq_t q, input int maxgap);
    foreach (q[i]) send_byte(q[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", {CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY});
    end
    RST_N = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", {CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY});
    end
  endtask

  task automatic test_write();
    bq_t q = frame("W 12AB 0000CAFE");
    res_t got, exp_r;
    CMD_READY = 1'b1;
    for (int i = 0; i < q.size() - 1; i++) send_byte(q[i], 0);
    n_checks++;
    if ({CMD_VALID, BUSY} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_before_lf: valid,busy got %b expected 01", {CMD_VALID, BUSY});
    end
    send_byte(8'h0A, 0);
    n_checks++;
    if (CMD_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL write_latency: valid got %b expected 1", CMD_VALID);
    end
    wait_results(1);
    exp_r = {1'b1, 1'b0, 16'h12AB, 32'h0000CAFE, 1'b0, 2'd0};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL write_frame: got %h expected %h", got, exp_r);
    end
  endtask

  task automatic test_read_and_error();
    bq_t q;
    res_t got, exp_r;
    bit early = 1'b0;
    CMD_READY = 1'b1;
    send_q(frame("R 00FF"), 0);
    wait_results(1);
    exp_r = {1'b0, 1'b1, 16'h00FF, 32'h0, 1'b0, 2'd0};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL read_frame: got %h expected %h", got, exp_r);
    end
    q = frame("W 12G4 00000000");
    for (int i = 0; i < q.size() - 1; i++) begin
      send_byte(q[i], 0);
      if (CMD_VALID) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL error_before_lf: early valid got %b expected 0", early);
    end
    send_byte(8'h0A, 0);
    wait_results(1);
    exp_r = {1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 2'd1};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL syntax_error: got %h expected %h", got, exp_r);
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    res_t got, exp_r;
    CMD_READY = 1'b1;
    send_q(str2q("W 12"), 0);
    while (!CMD_VALID && cyc < 200) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != TO) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", cyc, TO);
    end
    wait_results(1);
    exp_r = {1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 2'd2};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL timeout_result: got %h expected %h", got, exp_r);
    end
    send_q(frame("R 0001"), 0);
    wait_results(1);
    exp_r = {1'b0, 1'b1, 16'h0001, 32'h0, 1'b0, 2'd0};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL after_timeout_read: got %h expected %h", got, exp_r);
    end
  endtask

  task automatic test_backpressure();
    int base;
    res_t got, exp_r;
    CMD_READY = 1'b0;
    base = ovr_cnt;
    send_q(frame("R 0001"), 0);
    repeat (2) tick();
    n_checks++;
    if (CMD_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid_held: got %b expected 1", CMD_VALID);
    end
    send_byte("R", 0);
    n_checks++;
    if (OVERRUN !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun_pulse: got %b expected 1", OVERRUN);
    end
    repeat (3) tick();
    n_checks++;
    if (ovr_cnt - base != 1) begin
      n_fail++;
      $display("FAIL bp_overrun_count: got %0d expected 1", ovr_cnt - base);
    end
    n_checks++;
    if ({CMD_VALID, CMD_RD, ADDR} !== {1'b1, 1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL bp_result_stable: got %h expected %h", {CMD_VALID, CMD_RD, ADDR}, {1'b1, 1'b1, 16'h0001});
    end
    CMD_READY = 1'b1;
    send_q(frame("R 0002"), 0);
    wait_results(2);
    exp_r = {1'b0, 1'b1, 16'h0001, 32'h0, 1'b0, 2'd0};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL bp_first_result: got %h expected %h", got, exp_r);
    end
    exp_r = {1'b0, 1'b1, 16'h0002, 32'h0, 1'b0, 2'd0};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL bp_handshake_byte: got %h expected %h", got, exp_r);
    end
    n_checks++;
    if (ovr_cnt - base != 1) begin
      n_fail++;
      $display("FAIL bp_no_extra_overrun: got %0d expected 1", ovr_cnt - base);
    end
  endtask

  task automatic test_lowercase();
    res_t got, exp_r;
    CMD_READY = 1'b1;
    send_q(frame("w 00aa 0000000b"), 0);
    wait_results(1);
    exp_r = LOWER ? {1'b1, 1'b0, 16'h00AA, 32'h0000000B, 1'b0, 2'd0}
                  : {1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 2'd1};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL lowercase_frame: got %h expected %h", got, exp_r);
    end
  endtask

  task automatic test_reset_midframe();
    res_t got, exp_r;
    CMD_READY = 1'b1;
    send_q(str2q("W 12A"), 0);
    RST_N = 1'b0;
    #2;
    n_checks++;
    if ({CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_midframe: got %h expected 0", {CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY});
    end
    tick();
    RST_N = 1'b1;
    CMD_READY = 1'b0;
    send_q(frame("R 0003"), 0);
    tick();
    n_checks++;
    if (CMD_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold_setup: valid got %b expected 1", CMD_VALID);
    end
    RST_N = 1'b0;
    #2;
    n_checks++;
    if ({CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_midhold: got %h expected 0", {CMD_VALID, CMD_WR, CMD_RD, ADDR, DATA, FAIL, ERR_CODE, OVERRUN, BUSY});
    end
    tick();
    RST_N = 1'b1;
    CMD_READY = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_result: got %0d results expected 0", got_q.size());
    end
    send_q(frame("R 0004"), 0);
    wait_results(1);
    exp_r = {1'b0, 1'b1, 16'h0004, 32'h0, 1'b0, 2'd0};
    got = (got_q.size() > 0) ? got_q.pop_front() : '1;
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL reset_recovery: got %h expected %h", got, exp_r);
    end
  endtask

  task automatic test_random();
    bq_t q;
    res_t r, got;
    int n;
    CMD_READY = 1'b1;
    for (int f = 0; f < 40; f++) begin
      q = gen_frame();
      if (model_line(q, r)) exp_q.push_back(r);
      send_q(q, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
    wait_results(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      got = got_q.pop_front();
      r = exp_q.pop_front();
      n_checks++;
      if (got !== r) begin
        n_fail++;
        $display("FAIL random_result[%0d]: got %h expected %h", i, got, r);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_and_error();
    test_timeout();
    test_backpressure();
    test_lowercase();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
